// File: rtl/video_rx_capture.sv
// Video capture engine: RGB444 pixel stream framed by VSync/DE is written into
// an alternating double frame buffer over the UFI bus as a write-only master.
module video_rx_capture #(
  parameter int pBusAdrsBit    = 32,
  parameter int pUfiBusWidth   = 12,
  parameter int pHdisplayWidth = 11,
  parameter int pVdisplayWidth = 11,
  parameter int pFifoDepth     = 16
) (
  input  logic                      iSysClk,
  input  logic                      iSysRst,
  input  logic [3:0]                iVideoR,
  input  logic [3:0]                iVideoG,
  input  logic [3:0]                iVideoB,
  input  logic                      iVideoEn,
  input  logic                      iVideoDe,
  input  logic                      iVideoVSync,
  input  logic [pHdisplayWidth-1:0] iHdisplay,
  input  logic [pVdisplayWidth-1:0] iVdisplay,
  input  logic [pBusAdrsBit-1:0]    iFbufAdrs1,
  input  logic [pBusAdrsBit-1:0]    iFbufAdrs2,
  input  logic                      iCapEn,
  output logic [pUfiBusWidth-1:0]   oMUfiWd,
  output logic [pBusAdrsBit-1:0]    oMUfiAdrs,
  output logic                      oMUfiWEd,
  output logic                      oMUfiVd,
  output logic                      oMUfiCmd,
  input  logic                      iMUfiRdy,
  output logic                      oFrameDone,
  output logic                      oBufSel,
  output logic                      oOverflow,
  output logic                      oFrameErr
);

  localparam int TGT_W = pHdisplayWidth + pVdisplayWidth;
  localparam int PTR_W = $clog2(pFifoDepth);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;

  state_t                    state, state_next;
  logic                      vsync_prev;
  logic                      rise;
  logic [TGT_W-1:0]          target;
  logic [TGT_W-1:0]          pix_cnt;
  logic [pBusAdrsBit-1:0]    base;
  logic [pBusAdrsBit-1:0]    wr_cnt;
  logic                      room;
  logic                      start;
  logic                      accept;
  logic                      short_frame;
  logic                      last_pixel;
  logic                      flag_clear;

  logic                      stage_vld;
  logic [pUfiBusWidth-1:0]   stage_pix;
  logic [pUfiBusWidth-1:0]   fifo_mem [pFifoDepth];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      push;
  logic                      pop;
  logic                      drop;
  logic                      xfer;

  assign rise        = iVideoVSync & ~vsync_prev;
  assign room        = pix_cnt < target;
  assign start       = (state == IDLE) && iCapEn && rise;
  // A rise inside the frame ends it early, so it takes priority over a pixel.
  assign accept      = (state == CAPTURE) && iCapEn && !rise && iVideoEn && iVideoDe && room;
  assign short_frame = (state == CAPTURE) && iCapEn && rise && room;
  assign last_pixel  = accept && ((pix_cnt + TGT_W'(1)) == target);
  assign flag_clear  = (state == IDLE) && !iCapEn;

  // Pointer FIFO without a wrap bit: one slot stays free, so it holds
  // pFifoDepth-1 pixels and the output register holds one more word.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = ((wr_ptr + PTR_W'(1)) == rd_ptr);
  assign xfer       = oMUfiWEd & iMUfiRdy;
  assign pop        = (state != IDLE) && !fifo_empty && (!oMUfiWEd || iMUfiRdy);
  assign push       = stage_vld && (!fifo_full || pop);
  assign drop       = stage_vld && fifo_full && !pop;

  assign oMUfiCmd   = 1'b0;
  assign oFrameDone = (state == DONE);
  assign oMUfiAdrs  = base + wr_cnt;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CAPTURE;
      CAPTURE: if (!iCapEn || short_frame || !room || last_pixel) state_next = FLUSH;
      FLUSH:   if (!stage_vld && fifo_empty && !oMUfiWEd) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      state      <= IDLE;
      vsync_prev <= 1'b0;
      target     <= '0;
      pix_cnt    <= '0;
      base       <= '0;
      wr_cnt     <= '0;
      oBufSel    <= 1'b0;
      oOverflow  <= 1'b0;
      oFrameErr  <= 1'b0;
    end else begin
      state      <= state_next;
      vsync_prev <= iVideoVSync;
      if (start) begin
        base    <= oBufSel ? iFbufAdrs2 : iFbufAdrs1;
        target  <= TGT_W'(iHdisplay) * TGT_W'(iVdisplay);
        pix_cnt <= '0;
        wr_cnt  <= '0;
      end else begin
        if (accept) pix_cnt <= pix_cnt + TGT_W'(1);
        if (xfer)   wr_cnt  <= wr_cnt + pBusAdrsBit'(1);
      end
      if (state == DONE) oBufSel <= ~oBufSel;
      if (flag_clear)       oOverflow <= 1'b0;
      else if (drop)        oOverflow <= 1'b1;
      if (flag_clear)       oFrameErr <= 1'b0;
      else if (short_frame) oFrameErr <= 1'b1;
    end
  end

  // Input stage and FIFO pointers; a dropped pixel still advanced pix_cnt above.
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      stage_vld <= 1'b0;
      stage_pix <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      stage_vld <= accept;
      if (accept) stage_pix <= {iVideoR, iVideoG, iVideoB};
      if (push)   wr_ptr    <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr    <= rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers alone define its contents.
  always_ff @(posedge iSysClk) begin
    if (push) fifo_mem[wr_ptr] <= stage_pix;
  end

  // Output register: holds word and address until the arbiter takes it.
  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      oMUfiWd  <= '0;
      oMUfiWEd <= 1'b0;
      oMUfiVd  <= 1'b0;
    end else begin
      if (pop) begin
        oMUfiWd  <= fifo_mem[rd_ptr];
        oMUfiWEd <= 1'b1;
      end else if (xfer) begin
        oMUfiWEd <= 1'b0;
      end
      if ((state == FLUSH) && (state_next == DONE)) oMUfiVd <= 1'b0;
      else if (pop)                                 oMUfiVd <= 1'b1;
    end
  end

endmodule

// File: tb/tb_video_rx_capture.sv
// Self-checking bench for video_rx_capture: directed frames plus randomized
// frames scored against a queue-based model of the expected frame-buffer writes.
module tb_video_rx_capture;

  localparam int AW    = 32;
  localparam int DW    = 12;
  localparam int HW    = 11;
  localparam int VW    = 11;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] BASE1 = 32'h100;
  localparam logic [AW-1:0] BASE2 = 32'h200;

  logic          clk;
  logic          rst;
  logic [3:0]    r, g, b;
  logic          en, de, vsync, cap_en, rdy;
  logic [HW-1:0] hdisp;
  logic [VW-1:0] vdisp;
  logic [AW-1:0] fb1, fb2;
  logic [DW-1:0] wd;
  logic [AW-1:0] adrs;
  logic          wed, vd, cmd, frame_done, buf_sel, overflow, frame_err;

  video_rx_capture #(
    .pBusAdrsBit(AW), .pUfiBusWidth(DW), .pHdisplayWidth(HW),
    .pVdisplayWidth(VW), .pFifoDepth(DEPTH)
  ) dut (
    .iSysClk(clk), .iSysRst(rst),
    .iVideoR(r), .iVideoG(g), .iVideoB(b),
    .iVideoEn(en), .iVideoDe(de), .iVideoVSync(vsync),
    .iHdisplay(hdisp), .iVdisplay(vdisp),
    .iFbufAdrs1(fb1), .iFbufAdrs2(fb2), .iCapEn(cap_en),
    .oMUfiWd(wd), .oMUfiAdrs(adrs), .oMUfiWEd(wed), .oMUfiVd(vd),
    .oMUfiCmd(cmd), .iMUfiRdy(rdy),
    .oFrameDone(frame_done), .oBufSel(buf_sel),
    .oOverflow(overflow), .oFrameErr(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_d[$];
  logic [AW-1:0] got_a[$];
  int            done_cnt  = 0;
  int            done_base = 0;
  int            m_target  = 0;
  bit            m_sel     = 1'b0;
  logic [AW-1:0] m_base;

  // 0: ready always, 1: toggle, 2: random, 3: held low
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = ~rdy;
      2:       rdy = 1'($urandom_range(0, 1));
      default: rdy = 1'b0;
    endcase
  end

  // Bus monitor: inputs change at posedge+1, so negedge values are what the next edge sees.
  bit            have_prev = 1'b0;
  logic          prev_wed, prev_rdy;
  logic [DW-1:0] prev_wd;
  logic [AW-1:0] prev_adrs;
  always @(negedge clk) begin
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && prev_wed && !prev_rdy) begin
        check("hold_wed", wed, 1'b1);
        check("hold_wd", wd, prev_wd);
        check("hold_adrs", adrs, prev_adrs);
      end
      if (wed && rdy) begin
        got_d.push_back(wd);
        got_a.push_back(adrs);
        check("vd_on_xfer", vd, 1'b1);
      end
      if (frame_done) begin
        done_cnt++;
        check("vd_in_done", vd, 1'b0);
      end
      have_prev = 1'b1;
      prev_wed  = wed;
      prev_rdy  = rdy;
      prev_wd   = wd;
      prev_adrs = adrs;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wd"}, wd, 0);
    check({tag, "_adrs"}, adrs, 0);
    check({tag, "_wed"}, wed, 0);
    check({tag, "_vd"}, vd, 0);
    check({tag, "_cmd"}, cmd, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_bufsel"}, buf_sel, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_err"}, frame_err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst   = 1'b0;
    m_sel = 1'b0;
  endtask

  task automatic start_frame(input int h, input int v, input bit clear_flags);
    hdisp = HW'(h);
    vdisp = VW'(v);
    if (clear_flags) begin
      cap_en = 1'b0;
      tick();
      check("ovf_cleared", overflow, 1'b0);
      check("err_cleared", frame_err, 1'b0);
    end
    exp_q.delete();
    got_d.delete();
    got_a.delete();
    m_target  = h * v;
    m_base    = m_sel ? BASE2 : BASE1;
    done_base = done_cnt;
    cap_en    = 1'b1;
    vsync     = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  // gap_mode 0: back-to-back, 1: random idle cycles, 2: one idle cycle between pixels
  task automatic drive_pixels(input int n, input int gap_mode, input bit seq, input logic [DW-1:0] first);
    logic [DW-1:0] v;
    int idle;
    for (int i = 0; i < n; i++) begin
      idle = 0;
      if (gap_mode == 1) idle = $urandom_range(0, 2);
      if (gap_mode == 2 && i != 0) idle = 1;
      for (int k = 0; k < idle; k++) begin
        case ($urandom_range(0, 2))
          0:       begin en = 1'b0; de = 1'b0; end
          1:       begin en = 1'b1; de = 1'b0; end
          default: begin en = 1'b0; de = 1'b1; end
        endcase
        {r, g, b} = 12'($urandom);
        tick();
      end
      v = seq ? first + DW'(i) : DW'($urandom);
      {r, g, b} = v;
      en = 1'b1;
      de = 1'b1;
      if (exp_q.size() < m_target) exp_q.push_back(v);
      tick();
    end
    en = 1'b0;
    de = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt == done_base && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("frame_done_pulses", done_cnt - done_base, 1);
    m_sel = ~m_sel;
    check("buf_sel", buf_sel, m_sel);
  endtask

  task automatic check_words(input bit allow_drop);
    int  n_exp = exp_q.size();
    int  n_got = got_d.size();
    int  j = 0;
    bit  in_order = 1'b1;
    if (!allow_drop) begin
      check("word_count", n_got, n_exp);
      for (int i = 0; i < n_got && i < n_exp; i++) begin
        check("word_data", got_d[i], exp_q[i]);
        check("word_adrs", got_a[i], m_base + AW'(i));
      end
      check("no_overflow", overflow, 1'b0);
    end else begin
      for (int i = 0; i < n_got; i++) begin
        check("word_adrs", got_a[i], m_base + AW'(i));
        while (j < n_exp && exp_q[j] != got_d[i]) j++;
        if (j >= n_exp) in_order = 1'b0;
        j++;
      end
      check("words_in_order", in_order, 1'b1);
      check("overflow_iff_drop", overflow, n_got < n_exp);
    end
  endtask

  task automatic run_frame(input int h, input int v, input int extra, input int gap_mode,
                           input int rmode, input bit seq, input logic [DW-1:0] first);
    rdy_mode = rmode;
    start_frame(h, v, 1'b1);
    drive_pixels(h * v + extra, gap_mode, seq, first);
    wait_done();
    check_words(rmode != 0);
    check("frame_err_clean", frame_err, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; {r, g, b} = '0; en = 1'b0; de = 1'b0; vsync = 1'b0; cap_en = 1'b0;
    rdy = 1'b1; hdisp = '0; vdisp = '0; fb1 = BASE1; fb2 = BASE2;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    tick();

    // Basic frame with first-word latency probe, then two more for double buffering
    rdy_mode = 0;
    start_frame(4, 2, 1'b1);
    fork
      drive_pixels(8, 0, 1'b1, 12'h001);
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("lat_n1_wed", wed, 1'b0);
        check("lat_n1_vd", vd, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("lat_n2_wed", wed, 1'b1);
        check("lat_n2_wd", wd, 12'h001);
        check("lat_n2_adrs", adrs, BASE1);
        check("lat_n2_vd", vd, 1'b1);
      end
    join
    wait_done();
    check_words(1'b0);
    run_frame(4, 2, 0, 0, 0, 1'b1, 12'h011);
    run_frame(4, 2, 0, 0, 0, 1'b1, 12'h021);

    // Backpressure: ready toggles, pixels paced to the drain rate
    run_frame(4, 2, 0, 2, 1, 1'b1, 12'h001);

    // Short frame, then rises in FLUSH and stray pixels must start nothing
    rdy_mode = 0;
    start_frame(4, 2, 1'b1);
    drive_pixels(5, 0, 1'b1, 12'h041);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    wait_done();
    check_words(1'b0);
    check("short_err", frame_err, 1'b1);
    done_base = done_cnt;
    drive_pixels(4, 0, 1'b1, 12'h051);
    repeat (20) tick();
    check("no_restart_words", got_d.size(), 5);
    check("no_restart_done", done_cnt - done_base, 0);
    vsync = 1'b0;
    tick();

    // Frame error is sticky through a following good frame
    start_frame(2, 2, 1'b0);
    drive_pixels(4, 0, 1'b1, 12'h061);
    wait_done();
    check_words(1'b0);
    check("err_sticky", frame_err, 1'b1);

    // Capture enable dropped mid-frame: remaining pixels ignored
    start_frame(4, 2, 1'b1);
    drive_pixels(3, 0, 1'b1, 12'h071);
    cap_en = 1'b0;
    tick();
    drive_pixels(2, 0, 1'b1, 12'h074);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    wait_done();
    check_words(1'b0);
    check("capen_no_err", frame_err, 1'b0);

    // Mid-frame reset after three words
    start_frame(4, 2, 1'b1);
    drive_pixels(6, 0, 1'b1, 12'h081);
    for (int k = 0; k < 50 && got_d.size() < 3; k++) tick();
    check("pre_reset_words", got_d.size() >= 3, 1'b1);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    m_sel = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    tick();
    run_frame(4, 2, 0, 0, 0, 1'b1, 12'h091);

    // Overflow: ready held low while 8 pixels arrive
    do_reset();
    rdy_mode = 3;
    start_frame(4, 2, 1'b1);
    drive_pixels(8, 0, 1'b1, 12'h001);
    repeat (5) tick();
    rdy_mode = 0;
    wait_done();
    check("ovf_words", got_d.size(), 4);
    for (int i = 0; i < got_d.size() && i < 4; i++) begin
      check("ovf_data", got_d[i], 12'h001 + DW'(i));
      check("ovf_adrs", got_a[i], BASE1 + AW'(i));
    end
    check("ovf_flag", overflow, 1'b1);
    check("ovf_no_err", frame_err, 1'b0);
    done_base = done_cnt;
    repeat (10) tick();
    check("ovf_single_done", done_cnt - done_base, 0);

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      run_frame($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 2), 1'b0, 12'h000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
